// File: rtl/pkt_prio_queue.sv
// Strict-priority packet buffer: one circular FIFO per priority level feeding
// a single registered output stage with a valid/ready handshake.
// Level 0 is the most urgent. Arrivals at a full level are dropped and counted,
// since the upstream source cannot be stalled.
module pkt_prio_queue #(
    parameter int DWIDTH      = 64,
    parameter int PRIOR_WIDTH = 3,
    parameter int QDEPTH      = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int NLVL       = 2 ** PRIOR_WIDTH,
    localparam int OCC_W      = $clog2(NLVL * QDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DWIDTH-1:0]      in_data,
    input  logic [PRIOR_WIDTH-1:0] in_prior,
    output logic                   out_valid,
    output logic [DWIDTH-1:0]      out_data,
    output logic [PRIOR_WIDTH-1:0] out_prior,
    input  logic                   out_ready,
    output logic [NLVL-1:0]        lvl_full,
    output logic [OCC_W-1:0]       occupancy,
    output logic [CNT_WIDTH-1:0]   drop_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [DWIDTH-1:0]      mem     [NLVL][QDEPTH];
    logic [PW-1:0]          wptr    [NLVL];
    logic [PW-1:0]          rptr    [NLVL];
    logic [CW-1:0]          cnt     [NLVL];
    logic [CW-1:0]          cnt_nxt [NLVL];
    logic [NLVL-1:0]        wr_vec;
    logic [NLVL-1:0]        rd_vec;
    logic                   free;
    logic                   pop;
    logic                   wr_en;
    logic [PRIOR_WIDTH-1:0] sel;

    // Pick the most urgent non-empty level and decide accepted writes, using pre-edge counts.
    always_comb begin
        free  = !out_valid || out_ready;
        pop   = 1'b0;
        sel   = '0;
        for (int k = NLVL - 1; k >= 0; k--) begin
            if (cnt[k] != '0) begin
                pop = 1'b1;
                sel = PRIOR_WIDTH'(k);
            end
        end
        pop   = pop && free;
        // A full level drops the write even if it is popped on the same edge.
        wr_en = in_valid && (cnt[in_prior] != CW'(QDEPTH));
        for (int k = 0; k < NLVL; k++) begin
            wr_vec[k]  = wr_en && (in_prior == PRIOR_WIDTH'(k));
            rd_vec[k]  = pop && (sel == PRIOR_WIDTH'(k));
            cnt_nxt[k] = cnt[k];
            if (wr_vec[k] && !rd_vec[k]) begin
                cnt_nxt[k] = cnt[k] + 1'b1;
            end else if (!wr_vec[k] && rd_vec[k]) begin
                cnt_nxt[k] = cnt[k] - 1'b1;
            end
        end
    end

    // Per-level pointers, counts and full flags; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NLVL; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                cnt[k]  <= '0;
            end
            lvl_full <= '0;
        end else begin
            for (int k = 0; k < NLVL; k++) begin
                if (wr_vec[k]) begin
                    wptr[k] <= wptr[k] + 1'b1;
                end
                if (rd_vec[k]) begin
                    rptr[k] <= rptr[k] + 1'b1;
                end
                cnt[k]      <= cnt_nxt[k];
                lvl_full[k] <= (cnt_nxt[k] == CW'(QDEPTH));
            end
        end
    end

    // Packet storage is left uninitialised; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[in_prior][wptr[in_prior]] <= in_data;
        end
    end

    // Output register: load the selected head when free, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_prior <= '0;
        end else if (free) begin
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= mem[sel][rptr[sel]];
                out_prior <= sel;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Total entries in the level FIFOs and the saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
            drop_cnt  <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(wr_en) - OCC_W'(pop);
            if (in_valid && !wr_en && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_prio_queue.sv
// Bench for pkt_prio_queue: queue-based reference model plus scoreboard,
// directed scenarios and a randomized traffic phase.
module tb_pkt_prio_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [2:0]  in_prior;
    logic        out_valid;
    logic [63:0] out_data;
    logic [2:0]  out_prior;
    logic        out_ready;
    logic [7:0]  lvl_full;
    logic [5:0]  occupancy;
    logic [15:0] drop_cnt;

    pkt_prio_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_prior(in_prior),
        .out_valid(out_valid), .out_data(out_data), .out_prior(out_prior),
        .out_ready(out_ready), .lvl_full(lvl_full),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mq [8][$];
    logic        m_valid;
    logic [63:0] m_data;
    logic [2:0]  m_prior;
    int          m_drop;
    logic [66:0] exp_q [$];
    logic [63:0] got_q [$];
    logic [2:0]  gotp_q [$];
    int          sent, taken;
    int          passes = 0;
    int          total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Model: one edge of the queue using the rules in plain queue terms.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
            m_valid = 1'b0; m_data = '0; m_prior = '0; m_drop = 0;
            exp_q.delete(); got_q.delete(); gotp_q.delete();
            sent = 0; taken = 0;
        end else begin
            bit full_before;
            full_before = in_valid && (mq[in_prior].size() >= 4);
            if (!m_valid || out_ready) begin
                m_valid = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (mq[k].size() > 0) begin
                        m_data  = mq[k].pop_front();
                        m_prior = 3'(k);
                        m_valid = 1'b1;
                        exp_q.push_back({m_prior, m_data});
                        break;
                    end
                end
            end
            if (in_valid) begin
                if (full_before) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq[in_prior].push_back(in_data);
                    sent++;
                end
            end
        end
    end

    // Monitor: compare DUT against the model and pop the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            int          occ;
            logic [7:0]  fl;
            logic [66:0] e;
            occ = 0;
            for (int k = 0; k < 8; k++) begin
                occ += mq[k].size();
                fl[k] = (mq[k].size() == 4);
            end
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_prior", 64'(out_prior), 64'(m_prior));
            end
            chk("occupancy", 64'(occupancy), 64'(occ));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("lvl_full", 64'(lvl_full), 64'(fl));
            total++;
            if (int'(occupancy) <= sent - taken) passes++;
            else $display("FAIL occ_bound: got %0d allowed %0d", occupancy, sent - taken);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL sb_empty: got data %0h expected no packet", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e[63:0]);
                    chk("sb_prior", 64'(out_prior), 64'(e[66:64]));
                end
                got_q.push_back(out_data);
                gotp_q.push_back(out_prior);
                taken++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] p, input logic [63:0] d);
        in_valid = 1'b1; in_prior = p; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((out_valid || occupancy != 0) && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n < 200) passes++;
        else $display("FAIL drain_timeout: got %0d cycles limit 200", n);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_prior = '0; out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_out_prior", 64'(out_prior), 64'd0);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("reset_lvl_full", 64'(lvl_full), 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single packet latency and one-cycle presence
        out_ready = 1'b1;
        send(3'd5, 64'hA5);
        chk("single_t1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("single_t2_valid", 64'(out_valid), 64'd1);
        chk("single_t2_data", out_data, 64'hA5);
        chk("single_t2_prior", 64'(out_prior), 64'd5);
        tick();
        chk("single_t3_valid", 64'(out_valid), 64'd0);

        // Priority order behind an occupied output register
        out_ready = 1'b0;
        got_q.delete(); gotp_q.delete();
        send(3'd0, 64'hFF);
        send(3'd7, 64'd1);
        send(3'd2, 64'd2);
        send(3'd4, 64'd3);
        send(3'd2, 64'd4);
        tick();
        drain();
        chk("prio_count", 64'(got_q.size()), 64'd5);
        if (got_q.size() == 5) begin
            chk("prio_d0", got_q[0], 64'hFF);
            chk("prio_d1", got_q[1], 64'd2);
            chk("prio_d2", got_q[2], 64'd4);
            chk("prio_d3", got_q[3], 64'd3);
            chk("prio_d4", got_q[4], 64'd1);
            chk("prio_p4", 64'(gotp_q[4]), 64'd7);
            chk("prio_p3", 64'(gotp_q[3]), 64'd4);
        end

        // Reset mid-traffic: stored packets must never emerge
        out_ready = 1'b0;
        send(3'd1, 64'h1001); send(3'd3, 64'h3001);
        send(3'd1, 64'h1002); send(3'd3, 64'h3002);
        tick();
        pulse_reset();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rst_no_old_data", 64'(got_q.size()), 64'd0);

        // Overflow of level 6
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(3'd6, 64'h60 + 64'(i));
        tick();
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("ovf_lvl_full6", 64'(lvl_full[6]), 64'd1);
        chk("ovf_occupancy", 64'(occupancy), 64'd4);
        got_q.delete(); gotp_q.delete();
        drain();
        chk("ovf_count", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < got_q.size() && i < 5; i++)
            chk("ovf_order", got_q[i], 64'h60 + 64'(i));

        // Backpressure: held packet stays put while urgent packets arrive
        pulse_reset();
        out_ready = 1'b0;
        send(3'd3, 64'h33);
        for (int i = 0; i < 10; i++) begin
            send(3'd0, 64'h100 + 64'(i));
            chk("hold_data", out_data, 64'h33);
            chk("hold_prior", 64'(out_prior), 64'd3);
        end
        chk("hold_drop_cnt", 64'(drop_cnt), 64'd6);
        got_q.delete(); gotp_q.delete();
        drain();
        chk("hold_count", 64'(got_q.size()), 64'd5);
        if (got_q.size() >= 2) begin
            chk("hold_first", got_q[0], 64'h33);
            chk("hold_next_data", got_q[1], 64'h100);
            chk("hold_next_prior", 64'(gotp_q[1]), 64'd0);
        end

        // Streaming 100 back-to-back packets, priorities 1..7
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++)
            send(3'($urandom_range(1, 7)), {$urandom, $urandom});
        drain();
        chk("stream_drops", 64'(drop_cnt), 64'd0);
        chk("stream_count", 64'(got_q.size()), 64'd100);

        // Random traffic with random backpressure
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prior  = 3'($urandom_range(0, 7));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
